// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle MIPS32 DIV/DIVU unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

    localparam int          DIV_WIDTH     = 32;
    localparam int          DIV_ITER      = 32;
    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    // Magnitude of a two's complement operand; passes the value through when
    // the operation is unsigned. 0x8000_0000 maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/bit32_subtractor.sv
// 32-bit unsigned subtractor: diff = a - b, borrow set when a < b.
// Latency: combinational.
// Backpressure: none.
module bit32_subtractor (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] diff,
    output logic        borrow
);

    assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/div_trial_sub.sv
// Restoring-division trial subtract of a 33-bit shifted remainder by a 32-bit divisor.
// Latency: combinational.
// Backpressure: none.
module div_trial_sub (
    input  logic [32:0] minuend,
    input  logic [31:0] divisor,
    output logic [31:0] diff,
    output logic        borrow
);

    logic lo_borrow;

    bit32_subtractor u_lo (
        .a      (minuend[31:0]),
        .b      (divisor),
        .diff   (diff),
        .borrow (lo_borrow)
    );

    // Bit 32 of the subtrahend is zero, so the top stage only absorbs the low
    // borrow. When no borrow comes out, bit 32 of the difference is zero (the
    // result is below the divisor), so only the low 32 bits are returned.
    assign borrow = ~minuend[32] & lo_borrow;

endmodule

// File: rtl/bit32_divider.sv
// Restoring shift/subtract divider for DIV and DIVU, one quotient bit per clock.
// Latency: done 34 cycles after start is presented (2 cycles for divide by zero).
// Backpressure: start is ignored while busy; the pipeline stalls on busy.
module bit32_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    div_state_e       state;
    logic [4:0]       cnt;
    // Restored partial remainder; always below the divisor, so 32 bits hold it.
    // The 33rd bit only exists transiently in the shifted trial value.
    logic [WIDTH-1:0] prem;
    // Dividend magnitude shifting out at the top while quotient bits shift in.
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] a_raw;
    logic             q_neg;
    logic             r_neg;
    logic             dz;

    logic [WIDTH:0]   prem_sh;
    logic [WIDTH-1:0] trial_diff;
    logic             trial_borrow;

    assign prem_sh = {prem, dvd[WIDTH-1]};

    div_trial_sub u_trial (
        .minuend (prem_sh),
        .divisor (dvs),
        .diff    (trial_diff),
        .borrow  (trial_borrow)
    );

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // Sequencer: operand capture, 32 restoring iterations, sign fix-up and result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= 5'd0;
            prem        <= '0;
            dvd         <= '0;
            dvs         <= '0;
            a_raw       <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dz          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_raw       <= a;
                        dvd         <= mag32(a, is_signed);
                        dvs         <= mag32(b, is_signed);
                        q_neg       <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg       <= is_signed & a[WIDTH-1];
                        prem        <= '0;
                        cnt         <= 5'd0;
                        dz          <= (b == '0);
                        div_by_zero <= 1'b0;
                        state       <= (b == '0) ? ST_FIX : ST_RUN;
                    end
                end
                ST_RUN: begin
                    // No borrow: divisor fits, keep the difference and emit a 1.
                    prem <= trial_borrow ? prem_sh[WIDTH-1:0] : trial_diff;
                    dvd  <= {dvd[WIDTH-2:0], ~trial_borrow};
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'(DIV_ITER - 1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (dz) begin
                        quotient    <= DIV0_QUOTIENT;
                        remainder   <= a_raw;
                        div_by_zero <= 1'b1;
                    end else begin
                        // Truncating division: quotient sign from both operands,
                        // remainder sign follows the dividend.
                        quotient  <= q_neg ? (~dvd + 32'd1) : dvd;
                        remainder <= r_neg ? (~prem + 32'd1) : prem;
                    end
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit32_divider.sv
// Randomized scoreboard bench for bit32_divider against an arithmetic model.
// Latency: checks done at 34 cycles after start (2 for divide by zero).
// Backpressure: stimulus waits for busy low before issuing.
module tb_bit32_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    bit32_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .a           (a),
        .b           (b),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          issue;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        last_valid = 1'b0;
    logic [31:0] last_q;
    logic [31:0] last_r;
    logic        just_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Truncating division computed on 64-bit integers from the operand values.
    function automatic exp_t model(input logic sgn, input logic [31:0] x, input logic [31:0] y);
        exp_t   e;
        longint sx, sy, ax, ay, q, r;
        e.issue = 0;
        if (y == 32'd0) begin
            e.q   = 32'hFFFF_FFFF;
            e.r   = x;
            e.dz  = 1'b1;
            e.lat = 2;
        end else begin
            if (sgn) begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
            end else begin
                sx = longint'({32'd0, x});
                sy = longint'({32'd0, y});
            end
            ax = (sx < 0) ? -sx : sx;
            ay = (sy < 0) ? -sy : sy;
            q  = ax / ay;
            r  = ax % ay;
            if ((sx < 0) != (sy < 0)) q = -q;
            if (sx < 0) r = -r;
            e.q   = 32'(q);
            e.r   = 32'(r);
            e.dz  = 1'b0;
            e.lat = 34;
        end
        return e;
    endfunction

    // Monitor: compares every done pulse with the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (just_done) begin
                just_done = 1'b0;
                check("done_pulse_width", {31'd0, done}, 32'd0);
                check("busy_after_done", {31'd0, busy}, 32'd0);
            end else if (done) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    check("quotient", quotient, e.q);
                    check("remainder", remainder, e.r);
                    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
                    check("latency", 32'(cyc - e.issue), 32'(e.lat));
                    check("busy_with_done", {31'd0, busy}, 32'd1);
                    last_q     = e.q;
                    last_r     = e.r;
                    last_valid = 1'b1;
                end
                just_done = 1'b1;
            end
        end
    end

    // Issue one operation at a negedge; returns one negedge after it was sampled.
    task automatic issue(input logic sgn, input logic [31:0] x, input logic [31:0] y, input bit push);
        int   g = 0;
        exp_t e;
        while (busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: got busy=1 expected 0 within 200 cycles");
            return;
        end
        if (last_valid) begin
            check("hold_quotient", quotient, last_q);
            check("hold_remainder", remainder, last_r);
        end
        start     = 1'b1;
        is_signed = sgn;
        a         = x;
        b         = y;
        if (push) begin
            e       = model(sgn, x, y);
            e.issue = cyc;
            sbq.push_back(e);
        end
        @(negedge clk);
        start     = 1'b0;
        is_signed = $urandom_range(0, 1) != 0;
        a         = $urandom;
        b         = $urandom;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("dz_clear_on_start", {31'd0, div_by_zero}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x, y;
        logic        sgn;
        int          g;

        rst = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dz", {31'd0, div_by_zero}, 32'd0);

        // Directed cases, issued back to back.
        issue(1'b0, 32'd100, 32'd7, 1'b1);
        issue(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1);
        issue(1'b1, 32'd100, 32'hFFFF_FFF9, 1'b1);
        issue(1'b0, 32'h1234_5678, 32'd0, 1'b1);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1);
        issue(1'b0, 32'd5, 32'd9, 1'b1);

        // A start pulse during RUN with other operands must be ignored.
        issue(1'b0, 32'd1000, 32'd10, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        a     = 32'd77;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;

        // Reset at RUN cycle 10 discards the in-flight operation.
        issue(1'b0, 32'd50000, 32'd3, 1'b1);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        void'(sbq.pop_back());
        @(negedge clk);
        rst = 1'b0;
        last_valid = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_quotient", quotient, 32'd0);
        check("midrst_remainder", remainder, 32'd0);
        check("midrst_dz", {31'd0, div_by_zero}, 32'd0);
        repeat (40) @(negedge clk);
        issue(1'b0, 32'd9, 32'd3, 1'b1);

        // Randomized operations with biased divisors.
        for (int i = 0; i < 40; i++) begin
            sgn = $urandom_range(0, 1) != 0;
            x   = $urandom;
            if ($urandom_range(0, 3) == 0) x = 32'($urandom_range(0, 255));
            case ($urandom_range(0, 4))
                0:       y = 32'd0;
                1:       y = 32'($urandom_range(1, 15));
                2:       y = 32'd0 - 32'($urandom_range(1, 15));
                default: y = $urandom;
            endcase
            issue(sgn, x, y, 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        g = 0;
        while (sbq.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (sbq.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending results expected 0", sbq.size());
        end
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
